// File: rtl/btn_down_pulser.sv
// btn_down_pulser
// Turns a raw, bouncy push-button into the single-cycle `down` step enable
// for the downstream 4-bit down-counter. The button is synchronised, the
// press and the release are both debounced, and one pulse is emitted per
// accepted press. With REPEAT_EN=1 the block also emits repeat pulses while
// the button stays held.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous, active-high reset
//   btn_in  raw asynchronous button level, 1 = pressed
//   down    registered single-cycle step pulse to the down-counter
//   level   registered debounced button level
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | button released and debounced, waiting for a press
// CHK_PRESS   | candidate press, counting stable high samples
// HELD        | press accepted, running the auto-repeat schedule
// CHK_RELEASE | candidate release, counting stable low samples

module btn_down_pulser #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 12,
  parameter int REPEAT_PERIOD   = 6,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic down,
  output logic level
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CHK_PRESS   = 2'd1,
    HELD        = 2'd2,
    CHK_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] R_PER   = CNT_W'(REPEAT_PERIOD);

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] rlim_q, rlim_d;
  logic             down_q, down_d;
  logic             level_q, level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      rlim_q  <= '0;
      down_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      rlim_q  <= rlim_d;
      down_q  <= down_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    rlim_d  = rlim_q;
    down_d  = 1'b0;
    level_d = level_q;

    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = CHK_PRESS;
          dcnt_d  = '0;
        end
      end

      CHK_PRESS: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (dcnt_q == DC_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          down_d  = 1'b1;
          rcnt_d  = '0;
          rlim_d  = R_DELAY;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end

      HELD: begin
        // rcnt is left untouched on the way out so a short glitch only
        // pauses the repeat schedule instead of restarting it.
        if (!s2_q) begin
          state_d = CHK_RELEASE;
          dcnt_d  = '0;
        end else if (REPEAT_EN != 0) begin
          if (rcnt_q == rlim_q - ONE) begin
            down_d = 1'b1;
            rcnt_d = '0;
            rlim_d = R_PER;
          end else begin
            rcnt_d = rcnt_q + ONE;
          end
        end
      end

      CHK_RELEASE: begin
        if (s2_q) begin
          state_d = HELD;
        end else if (dcnt_q == DC_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign down  = down_q;
  assign level = level_q;

endmodule

// File: tb/tb_btn_down_pulser.sv
module tb_btn_down_pulser;

  localparam int D  = 4;
  localparam int RD = 12;
  localparam int RP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic down_a, level_a, down_b, level_b;

  always #5 clk = ~clk;

  btn_down_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .btn_in(btn_in), .down(down_a), .level(level_a));

  btn_down_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .btn_in(btn_in), .down(down_b), .level(level_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
    return s;
  endfunction

  task automatic check_q(input string name, input int got[$], input int exp[$]);
    bit ok;
    ok = (got.size() == exp.size());
    if (ok) foreach (got[i]) if (got[i] != exp[i]) ok = 1'b0;
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got [%s ] expected [%s ]", name, q2s(got), q2s(exp));
  endtask

  // Model: a press is accepted once the synchronised level has been seen
  // high for D+1 consecutive edges, a release once seen low for D+1.
  // While accepted, every edge that sees the button high for the second
  // edge running earns one unit of hold time; a repeat fires when the
  // earned hold time reaches the current target (RD first, then RP).
  typedef struct {
    bit s1, s2, prev;
    int run1, run0, hold, target;
    bit level, down;
  } model_t;

  function automatic model_t step(input model_t m, input bit r, input bit b, input bit rep);
    model_t n;
    bit x;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    x = m.s2;
    n.down = 1'b0;
    if (x) begin n.run1 = m.run1 + 1; n.run0 = 0; end
    else   begin n.run0 = m.run0 + 1; n.run1 = 0; end
    if (!m.level) begin
      if (x && n.run1 == D + 1) begin
        n.level = 1'b1; n.down = 1'b1; n.hold = 0; n.target = RD;
      end
    end else if (!x && n.run0 == D + 1) begin
      n.level = 1'b0;
    end else if (x && m.prev && rep) begin
      n.hold = m.hold + 1;
      if (n.hold == m.target) begin
        n.down = 1'b1; n.hold = 0; n.target = RP;
      end
    end
    n.prev = x;
    n.s2 = m.s1;
    n.s1 = b;
    return n;
  endfunction

  model_t ma = '{default: 0};
  model_t mb = '{default: 0};
  int ecnt = 0;

  always @(posedge clk) begin
    ma = step(ma, rst, btn_in, 1'b1);
    mb = step(mb, rst, btn_in, 1'b0);
    ecnt++;
  end

  bit chk_en = 1'b0;
  int base = 0;
  int qa[$];
  int qb[$];
  int rise_a = -1;
  int fall_a = -1;
  bit lvl_prev = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("down_a", int'(down_a), int'(ma.down));
      check("level_a", int'(level_a), int'(ma.level));
      check("down_b", int'(down_b), int'(mb.down));
      check("level_b", int'(level_b), int'(mb.level));
      if (down_a) qa.push_back(ecnt - base);
      if (down_b) qb.push_back(ecnt - base);
      if (!lvl_prev && level_a) rise_a = ecnt - base;
      if (lvl_prev && !level_a) fall_a = ecnt - base;
      lvl_prev = level_a;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start();
    qa.delete();
    qb.delete();
    rise_a = -1;
    fall_a = -1;
    base = ecnt;
  endtask

  bit pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; btn_in = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc(5);

    // 1: button held through reset counts as a fresh press
    rst = 1'b1; btn_in = 1'b1;
    cyc(2);
    check("rst_level", int'(level_a), 0);
    rst = 1'b0;
    start();
    cyc(12);
    check("t1_level", int'(level_a), 1);
    btn_in = 1'b0;
    cyc(20);
    check_q("t1_pulses", qa, '{7});
    check("t1_rise", rise_a, 7);

    // 2: clean press, released before the first repeat
    start();
    btn_in = 1'b1;
    cyc(10);
    btn_in = 1'b0;
    cyc(20);
    check_q("t2_pulses", qa, '{7});
    check("t2_rise", rise_a, 7);
    check("t2_fall", fall_a, 17);

    // 3: bounce shorter than the debounce window
    start();
    foreach (pat[i]) begin
      btn_in = pat[i];
      cyc(1);
    end
    btn_in = 1'b0;
    cyc(15);
    check("t3_npulses", qa.size(), 0);
    check("t3_rise", rise_a, -1);

    // 4: long hold, with and without auto-repeat
    start();
    btn_in = 1'b1;
    cyc(45);
    btn_in = 1'b0;
    cyc(20);
    check_q("t4_pulses_rep", qa, '{7, 19, 25, 31, 37, 43});
    check_q("t4_pulses_norep", qb, '{7});
    check("t4_fall", fall_a, 52);

    // 5: one-cycle glitch during the hold
    start();
    btn_in = 1'b1;
    cyc(11);
    btn_in = 1'b0;
    cyc(1);
    btn_in = 1'b1;
    cyc(12);
    btn_in = 1'b0;
    cyc(20);
    check_q("t5_pulses", qa, '{7, 21});
    check_q("t5_pulses_norep", qb, '{7});
    check("t5_fall", fall_a, 31);

    // 6: reset in the middle of a hold
    start();
    btn_in = 1'b1;
    cyc(21);
    rst = 1'b1;
    cyc(1);
    check("t6_rst_level", int'(level_a), 0);
    check("t6_rst_down", int'(down_a), 0);
    rst = 1'b0;
    cyc(18);
    btn_in = 1'b0;
    cyc(20);
    check_q("t6_pulses", qa, '{7, 19, 29, 41});
    check_q("t6_pulses_norep", qb, '{7, 29});
    check("t6_fall", fall_a, 47);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
